minmax_tracker: RTL and testbench

//   Consumes a stream of unsigned WIDTH-bit samples over a valid/ready handshake.

---
 rtl/minmax_tracker_pkg.sv | 16 +
 rtl/minmax_tracker_mag_cmp_nb.sv | 16 +
 rtl/minmax_tracker.sv | 119 +++++++++++
 tb/tb_minmax_tracker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_tracker_pkg.sv
// Shared types for the window min/max tracker: FSM state encoding and
// counter sizing helper.
package minmax_tracker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Counter must be able to represent WIN itself, not just WIN-1.
   function automatic int cnt_width(input int win);
      return (win < 1) ? 1 : $clog2(win + 1);
   endfunction

endpackage

// File: rtl/minmax_tracker_mag_cmp_nb.sv
// Unsigned magnitude comparator; exactly one of gt/lt/eq is high.
module mag_cmp_nb #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/minmax_tracker.sv
// Running max/min over a window of WIN unsigned samples, with valid/ready
// on both sides; result held in registered outputs until consumed.
module minmax_tracker
   import minmax_tracker_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int WIN   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic             out_all_eq
);

   localparam int            CW    = cnt_width(WIN);
   localparam logic [CW-1:0] WIN_C = CW'(WIN);

   state_e           state;
   logic [WIDTH-1:0] max_q, min_q;
   logic [CW-1:0]    cnt_q;

   logic             s_gt_max, s_lt_min, nxt_eq;
   logic [WIDTH-1:0] nxt_max, nxt_min;
   logic [CW-1:0]    cnt_nxt;
   logic             in_xfer, win_done, first;

   logic             unused_cmp_gt, unused_cmp_lt, unused_eq_max, unused_eq_min;
   logic             unused_lt_max, unused_gt_min;

   assign in_ready = (state != ST_HOLD);
   assign in_xfer  = in_valid & in_ready;
   assign first    = (state == ST_IDLE);

   mag_cmp_nb #(.WIDTH(WIDTH)) u_cmp_max (
      .a  (in_data),
      .b  (max_q),
      .gt (s_gt_max),
      .lt (unused_lt_max),
      .eq (unused_eq_max)
   );

   mag_cmp_nb #(.WIDTH(WIDTH)) u_cmp_min (
      .a  (in_data),
      .b  (min_q),
      .gt (unused_gt_min),
      .lt (s_lt_min),
      .eq (unused_eq_min)
   );

   // First sample of a window seeds both trackers regardless of stale regs.
   assign nxt_max  = (first || s_gt_max) ? in_data : max_q;
   assign nxt_min  = (first || s_lt_min) ? in_data : min_q;
   assign cnt_nxt  = first ? CW'(1) : cnt_q + 1'b1;
   assign win_done = (cnt_nxt == WIN_C);

   mag_cmp_nb #(.WIDTH(WIDTH)) u_cmp_eq (
      .a  (nxt_max),
      .b  (nxt_min),
      .gt (unused_cmp_gt),
      .lt (unused_cmp_lt),
      .eq (nxt_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         max_q      <= '0;
         min_q      <= '0;
         cnt_q      <= '0;
         out_valid  <= 1'b0;
         out_max    <= '0;
         out_min    <= '0;
         out_all_eq <= 1'b0;
      end else if (flush) begin
         state     <= ST_IDLE;
         cnt_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_ACCUM: begin
               if (in_xfer) begin
                  max_q <= nxt_max;
                  min_q <= nxt_min;
                  cnt_q <= cnt_nxt;
                  if (win_done) begin
                     state      <= ST_HOLD;
                     out_valid  <= 1'b1;
                     out_max    <= nxt_max;
                     out_min    <= nxt_min;
                     out_all_eq <= nxt_eq;
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  cnt_q     <= '0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               cnt_q     <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minmax_tracker.sv
// Randomized and directed bench for minmax_tracker (WIN=4 and WIN=1 instances).
module tb_minmax_tracker;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, flush, in_valid, out_ready;
   logic [2:0] in_data;
   logic       in_ready, out_valid, out_all_eq;
   logic [2:0] out_max, out_min;

   logic       flush_1, in_valid_1, out_ready_1;
   logic [2:0] in_data_1;
   logic       in_ready_1, out_valid_1, out_all_eq_1;
   logic [2:0] out_max_1, out_min_1;

   int total = 0;
   int bad   = 0;

   logic [2:0] win_q[$];

   minmax_tracker #(.WIDTH(3), .WIN(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_min(out_min), .out_all_eq(out_all_eq)
   );

   minmax_tracker #(.WIDTH(3), .WIN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush_1),
      .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1),
      .out_max(out_max_1), .out_min(out_min_1), .out_all_eq(out_all_eq_1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Feeds win_q (4 samples) with optional gaps, then stalls the result.
   task automatic run_window(input string tag, input int gap_max, input int stall);
      logic [2:0] emax, emin;
      logic       eeq;
      emax = win_q[0];
      emin = win_q[0];
      foreach (win_q[k]) begin
         if (win_q[k] > emax) emax = win_q[k];
         if (win_q[k] < emin) emin = win_q[k];
      end
      eeq = (emax == emin);
      for (int i = 0; i < 4; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         for (int j = 0; j < g; j++) begin
            in_valid = 1'b0;
            step();
         end
         in_valid = 1'b1;
         in_data  = win_q[i];
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s accept%0d: in_ready=%b out_valid=%b want 1/0", tag, i, in_ready, out_valid);
         end
         step();
      end
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_max, out_min, out_all_eq} !== {1'b1, emax, emin, eeq}) begin
         bad++;
         $display("FAIL %s result: v=%b max=%0d min=%0d eq=%b want v=1 max=%0d min=%0d eq=%b",
                  tag, out_valid, out_max, out_min, out_all_eq, emax, emin, eeq);
      end
      for (int s = 0; s < stall; s++) begin
         in_valid  = 1'b1;
         in_data   = 3'($urandom);
         out_ready = 1'b0;
         step();
         total++;
         if ({out_valid, in_ready, out_max, out_min, out_all_eq} !== {1'b1, 1'b0, emax, emin, eeq}) begin
            bad++;
            $display("FAIL %s stall%0d: v=%b rdy=%b max=%0d min=%0d eq=%b want v=1 rdy=0 max=%0d min=%0d eq=%b",
                     tag, s, out_valid, in_ready, out_max, out_min, out_all_eq, emax, emin, eeq);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s drain: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
      end
      win_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      total++;
      if ({out_valid, in_ready, out_max, out_min, out_all_eq} !== {1'b0, 1'b1, 3'd0, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: v=%b rdy=%b max=%0d min=%0d eq=%b want 0 1 0 0 0",
                  out_valid, in_ready, out_max, out_min, out_all_eq);
      end
      // two samples, then async reset mid-window
      in_valid = 1'b1;
      in_data  = 3'd0;
      step();
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_max, out_min} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
         bad++;
         $display("FAIL reset_mid: v=%b rdy=%b max=%0d min=%0d want 0 1 0 0", out_valid, in_ready, out_max, out_min);
      end
      rst_n = 1'b1;
      step();
      win_q = '{3'd4, 3'd5, 3'd6, 3'd7};
      run_window("reset_fresh", 0, 0);
      // reset while holding a result
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 3'd3;
         step();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_max, out_min, out_all_eq} !== {1'b0, 1'b1, 3'd0, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_hold: v=%b rdy=%b max=%0d min=%0d eq=%b want 0 1 0 0 0",
                  out_valid, in_ready, out_max, out_min, out_all_eq);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_directed();
      win_q = '{3'd3, 3'd1, 3'd6, 3'd2};
      run_window("stream_3162", 0, 0);
      win_q = '{3'd5, 3'd5, 3'd5, 3'd5};
      run_window("all_equal", 0, 0);
      win_q = '{3'd7, 3'd0, 3'd7, 3'd0};
      run_window("gaps_stall", 2, 3);
      win_q = '{3'd0, 3'd0, 3'd0, 3'd0};
      run_window("all_zero", 0, 1);
      win_q = '{3'd2, 3'd7, 3'd7, 3'd7};
      run_window("eq_max_kept", 0, 0);
   endtask

   task automatic test_flush();
      in_valid = 1'b1;
      in_data  = 3'd2;
      step();
      in_data  = 3'd6;
      step();
      flush    = 1'b1;
      in_data  = 3'd7;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_accum: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      win_q = '{3'd2, 3'd4, 3'd4, 3'd3};
      run_window("after_flush", 0, 0);
      // flush discards a held result
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 3'd1;
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_hold: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      win_q = '{3'd6, 3'd3, 3'd5, 3'd4};
      run_window("after_flush_hold", 0, 0);
   endtask

   task automatic test_random();
      for (int w = 0; w < 25; w++) begin
         logic [2:0] v;
         v = 3'($urandom);
         for (int i = 0; i < 4; i++)
            win_q.push_back(($urandom_range(0, 3) == 0) ? v : 3'($urandom));
         run_window("random", 2, int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_win1();
      logic [2:0] smp[2];
      smp[0] = 3'd4;
      smp[1] = 3'd1;
      out_ready_1 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_valid_1 = 1'b1;
         in_data_1  = smp[i];
         total++;
         if (in_ready_1 !== 1'b1 || out_valid_1 !== 1'b0) begin
            bad++;
            $display("FAIL win1_accept%0d: in_ready=%b out_valid=%b want 1/0", i, in_ready_1, out_valid_1);
         end
         step();
         in_valid_1 = 1'b0;
         total++;
         if ({out_valid_1, in_ready_1, out_max_1, out_min_1, out_all_eq_1} !== {1'b1, 1'b0, smp[i], smp[i], 1'b1}) begin
            bad++;
            $display("FAIL win1_result%0d: v=%b rdy=%b max=%0d min=%0d eq=%b want 1 0 %0d %0d 1",
                     i, out_valid_1, in_ready_1, out_max_1, out_min_1, out_all_eq_1, smp[i], smp[i]);
         end
         step();
         total++;
         if (out_valid_1 !== 1'b0 || in_ready_1 !== 1'b1) begin
            bad++;
            $display("FAIL win1_drain%0d: out_valid=%b in_ready=%b want 0/1", i, out_valid_1, in_ready_1);
         end
      end
      out_ready_1 = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      flush_1     = 1'b0;
      in_valid_1  = 1'b0;
      in_data_1   = '0;
      out_ready_1 = 1'b0;
      test_reset();
      test_directed();
      test_flush();
      test_random();
      test_win1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
